light_conflict_monitor: RTL and testbench

Safety stage directly downstream of the 2-way traffic light controller. It consumes the controller's ns/ew light codes, checks every cycle for illegal, conflicting, out-of-sequence or mistimed aspects, and drives the physical lamps. On any violation it latches a fault code and forces both approaches to flashing red until cleared.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/light_transition_check.sv | 32 +++
 rtl/light_conflict_monitor.sv | 147 ++++++++++++++
 tb/tb_light_conflict_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light codes, fault codes and monitor state encoding
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    typedef enum logic [2:0] {
        FLT_NONE         = 3'd0,
        FLT_ILLEGAL      = 3'd1,
        FLT_CONFLICT     = 3'd2,
        FLT_SEQUENCE     = 3'd3,
        FLT_SHORT_YELLOW = 3'd4,
        FLT_SHORT_ALLRED = 3'd5,
        FLT_STUCK        = 3'd6
    } fault_code_e;

    typedef enum logic [1:0] {
        MON_STARTUP = 2'd0,
        MON_NORMAL  = 2'd1,
        MON_FAULT   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/light_transition_check.sv
// rtl/light_transition_check.sv - per-direction legality and timing check of a requested aspect
module light_transition_check
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW_CYCLES = 20,
    parameter int unsigned MIN_ALLRED_CYCLES = 10
) (
    input  logic [2:0]  prev,
    input  logic [2:0]  req,
    input  logic [31:0] hold_cnt,
    output logic        illegal,
    output logic        bad_sequence,
    output logic        short_yellow,
    output logic        short_allred,
    output logic        changed
);

    assign changed = (req != prev);
    assign illegal = !((req == LIGHT_RED) || (req == LIGHT_YELLOW) || (req == LIGHT_GREEN));

    // Only the forward cycle G->Y->R->G is a legal change of aspect.
    assign bad_sequence = changed &&
        !(((prev == LIGHT_GREEN)  && (req == LIGHT_YELLOW)) ||
          ((prev == LIGHT_YELLOW) && (req == LIGHT_RED))    ||
          ((prev == LIGHT_RED)    && (req == LIGHT_GREEN)));

    assign short_yellow = (prev == LIGHT_YELLOW) && (req == LIGHT_RED) &&
                          (hold_cnt < MIN_YELLOW_CYCLES);
    assign short_allred = (prev == LIGHT_RED) && (req == LIGHT_GREEN) &&
                          (hold_cnt < MIN_ALLRED_CYCLES);

endmodule

// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - safety monitor between the light controller and the lamp drivers
module light_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW_CYCLES = 20,
    parameter int unsigned MIN_ALLRED_CYCLES = 10,
    parameter int unsigned MAX_PHASE_CYCLES  = 200,
    parameter int unsigned FLASH_HALF_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns_light_in,
    input  logic [2:0] ew_light_in,
    input  logic       fault_clear,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    mon_state_e  state, state_nx;
    logic [31:0] hold_cnt, hold_nx, flash_cnt, flash_nx;
    logic [2:0]  ns_nx, ew_nx, code_nx, fail_code;
    logic        fault_nx, hold_restart, flash_on;
    logic        ns_illegal, ns_bad_seq, ns_short_y, ns_short_ar, ns_changed;
    logic        ew_illegal, ew_bad_seq, ew_short_y, ew_short_ar, ew_changed;

    light_transition_check #(
        .MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES),
        .MIN_ALLRED_CYCLES(MIN_ALLRED_CYCLES)
    ) u_ns_check (
        .prev(ns_lamp), .req(ns_light_in), .hold_cnt(hold_cnt),
        .illegal(ns_illegal), .bad_sequence(ns_bad_seq), .short_yellow(ns_short_y),
        .short_allred(ns_short_ar), .changed(ns_changed)
    );

    light_transition_check #(
        .MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES),
        .MIN_ALLRED_CYCLES(MIN_ALLRED_CYCLES)
    ) u_ew_check (
        .prev(ew_lamp), .req(ew_light_in), .hold_cnt(hold_cnt),
        .illegal(ew_illegal), .bad_sequence(ew_bad_seq), .short_yellow(ew_short_y),
        .short_allred(ew_short_ar), .changed(ew_changed)
    );

    // Lowest failing code wins.
    always_comb begin : fail_priority
        fail_code = FLT_NONE;
        if (ns_illegal || ew_illegal)
            fail_code = FLT_ILLEGAL;
        else if ((ns_light_in != LIGHT_RED) && (ew_light_in != LIGHT_RED))
            fail_code = FLT_CONFLICT;
        else if (ns_bad_seq || ew_bad_seq || (ns_changed && ew_changed))
            fail_code = FLT_SEQUENCE;
        else if (ns_short_y || ew_short_y)
            fail_code = FLT_SHORT_YELLOW;
        else if (ns_short_ar || ew_short_ar)
            fail_code = FLT_SHORT_ALLRED;
        else if (!ns_changed && !ew_changed && (hold_cnt >= MAX_PHASE_CYCLES))
            fail_code = FLT_STUCK;
    end

    always_comb begin : next_state
        state_nx     = state;
        ns_nx        = ns_lamp;
        ew_nx        = ew_lamp;
        fault_nx     = fault;
        code_nx      = fault_code;
        flash_nx     = flash_cnt;
        hold_restart = 1'b0;
        flash_on     = (flash_cnt == FLASH_HALF_CYCLES) ? ~ns_lamp[2] : ns_lamp[2];

        case (state)
            MON_STARTUP: begin
                ns_nx = LIGHT_RED;
                ew_nx = LIGHT_RED;
                if (hold_cnt >= MIN_ALLRED_CYCLES)
                    state_nx = MON_NORMAL;
            end
            MON_NORMAL: begin
                if (fail_code != FLT_NONE) begin
                    state_nx = MON_FAULT;
                    fault_nx = 1'b1;
                    code_nx  = fail_code;
                    ns_nx    = LIGHT_RED;
                    ew_nx    = LIGHT_RED;
                    flash_nx = 32'd1;
                end else begin
                    ns_nx = ns_light_in;
                    ew_nx = ew_light_in;
                end
            end
            MON_FAULT: begin
                if (fault_clear) begin
                    state_nx     = MON_STARTUP;
                    ns_nx        = LIGHT_RED;
                    ew_nx        = LIGHT_RED;
                    fault_nx     = 1'b0;
                    code_nx      = FLT_NONE;
                    flash_nx     = 32'd1;
                    hold_restart = 1'b1;
                end else begin
                    ns_nx    = flash_on ? LIGHT_RED : LIGHT_OFF;
                    ew_nx    = flash_on ? LIGHT_RED : LIGHT_OFF;
                    flash_nx = (flash_cnt == FLASH_HALF_CYCLES) ? 32'd1 : flash_cnt + 32'd1;
                end
            end
            default: begin
                state_nx     = MON_STARTUP;
                ns_nx        = LIGHT_RED;
                ew_nx        = LIGHT_RED;
                fault_nx     = 1'b0;
                code_nx      = FLT_NONE;
                flash_nx     = 32'd1;
                hold_restart = 1'b1;
            end
        endcase

        if (hold_restart || (ns_nx != ns_lamp) || (ew_nx != ew_lamp))
            hold_nx = 32'd1;
        else if (hold_cnt < MAX_PHASE_CYCLES)
            hold_nx = hold_cnt + 32'd1;
        else
            hold_nx = hold_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MON_STARTUP;
            ns_lamp    <= LIGHT_RED;
            ew_lamp    <= LIGHT_RED;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            hold_cnt   <= 32'd1;
            flash_cnt  <= 32'd1;
        end else begin
            state      <= state_nx;
            ns_lamp    <= ns_nx;
            ew_lamp    <= ew_nx;
            fault      <= fault_nx;
            fault_code <= code_nx;
            hold_cnt   <= hold_nx;
            flash_cnt  <= flash_nx;
        end
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb/tb_light_conflict_monitor.sv - randomized self-checking bench for light_conflict_monitor
module tb_light_conflict_monitor;
    import traffic_pkg::*;

    localparam int MIN_Y  = 20;
    localparam int MIN_AR = 10;
    localparam int MAX_PH = 200;
    localparam int HALF   = 50;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fault_clear = 1'b0;
    logic [2:0] ns_light_in = 3'b100;
    logic [2:0] ew_light_in = 3'b100;
    logic [2:0] ns_lamp, ew_lamp, fault_code;
    logic       fault;

    always #5 clk = ~clk;

    light_conflict_monitor dut (
        .clk(clk), .rst(rst), .ns_light_in(ns_light_in), .ew_light_in(ew_light_in),
        .fault_clear(fault_clear), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
        .fault(fault), .fault_code(fault_code)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 startup, 1 normal, 2 fault; timing kept as edge numbers.
    int         m_mode = 0;
    logic [2:0] m_ns = 3'b100, m_ew = 3'b100, m_code = 3'd0;
    logic       m_fault = 1'b0;
    int         edge_n = 0, last_chg = 0, t0 = 0;

    int         fault_seen, n_green, p, q;
    bit         hit;
    logic [5:0] c;
    logic [2:0] rn, re;
    logic       rclr, rrst;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_aspect(input logic [2:0] x);
        return (x == R) || (x == Y) || (x == G);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] x);
        case (x)
            R:       return G;
            G:       return Y;
            Y:       return R;
            default: return R;
        endcase
    endfunction

    function automatic logic [2:0] eval_code(input logic [2:0] pn, input logic [2:0] pe,
                                             input logic [2:0] rqn, input logic [2:0] rqe,
                                             input int hold);
        if (!is_aspect(rqn) || !is_aspect(rqe)) return 3'd1;
        if (rqn != R && rqe != R) return 3'd2;
        if ((rqn != pn && rqn != succ(pn)) || (rqe != pe && rqe != succ(pe)) ||
            (rqn != pn && rqe != pe)) return 3'd3;
        if (((pn == Y && rqn == R) || (pe == Y && rqe == R)) && hold < MIN_Y) return 3'd4;
        if (((pn == R && rqn == G) || (pe == R && rqe == G)) && hold < MIN_AR) return 3'd5;
        if (rqn == pn && rqe == pe && hold >= MAX_PH) return 3'd6;
        return 3'd0;
    endfunction

    task automatic model_edge(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic r);
        int hold;
        logic [2:0] code, nn, ne;
        edge_n++;
        hold = edge_n - last_chg;
        if (hold > MAX_PH) hold = MAX_PH;
        if (r) begin
            m_mode = 0; m_ns = R; m_ew = R; m_fault = 0; m_code = 0; last_chg = edge_n;
        end else if (m_mode == 0) begin
            if (hold >= MIN_AR) m_mode = 1;
        end else if (m_mode == 1) begin
            code = eval_code(m_ns, m_ew, ns, ew, hold);
            if (code != 0) begin
                m_mode = 2; m_fault = 1; m_code = code; t0 = edge_n; nn = R; ne = R;
            end else begin
                nn = ns; ne = ew;
            end
            if (nn != m_ns || ne != m_ew) last_chg = edge_n;
            m_ns = nn;
            m_ew = ne;
        end else begin
            if (clr) begin
                m_mode = 0; m_ns = R; m_ew = R; m_fault = 0; m_code = 0; last_chg = edge_n;
            end else begin
                m_ns = (((edge_n - t0) / HALF) % 2 == 0) ? R : 3'b000;
                m_ew = m_ns;
            end
        end
    endtask

    task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic r);
        ns_light_in = ns;
        ew_light_in = ew;
        fault_clear = clr;
        rst = r;
        @(posedge clk);
        model_edge(ns, ew, clr, r);
        #1;
        check_eq("outputs", {22'd0, ns_lamp, ew_lamp, fault, fault_code},
                 {22'd0, m_ns, m_ew, m_fault, m_code});
    endtask

    // Upstream controller: NS green 100, yellow 20, all-red 10, then the same for EW.
    function automatic logic [5:0] ctrl_out(input int t);
        int ph;
        ph = t % 260;
        if (ph < 100) return {G, R};
        if (ph < 120) return {Y, R};
        if (ph < 130) return {R, R};
        if (ph < 230) return {R, G};
        if (ph < 250) return {R, Y};
        return {R, R};
    endfunction

    task automatic restart();
        step(R, R, 1'b1, 1'b0);
        repeat (11) step(R, R, 1'b0, 1'b0);
    endtask

    initial begin
        step(R, R, 1'b0, 1'b1);
        check_eq("rst_state", {22'd0, ns_lamp, ew_lamp, fault, fault_code}, {22'd0, 10'b100_100_0_000});

        fault_seen = 0;
        for (int k = 1; k <= 600; k++) begin
            c = ctrl_out(k - 1);
            step(c[5:3], c[2:0], 1'b0, 1'b0);
            if (fault) fault_seen++;
            if (k == 10) check_eq("startup_red", {26'd0, ns_lamp, ew_lamp}, {26'd0, R, R});
            if (k == 11) check_eq("first_track", {29'd0, ns_lamp}, {29'd0, G});
        end
        check_eq("ctrl_faults", fault_seen, 0);
        check_eq("pre_conflict", {26'd0, ns_lamp, ew_lamp}, {26'd0, G, R});

        step(G, G, 1'b0, 1'b0);
        check_eq("conflict", {22'd0, ns_lamp, ew_lamp, fault, fault_code}, {22'd0, R, R, 1'b1, 3'd2});
        for (int j = 1; j <= 100; j++) begin
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
            if (j == 49)  check_eq("flash_on_49", {29'd0, ns_lamp}, {29'd0, R});
            if (j == 50)  check_eq("flash_off_50", {29'd0, ns_lamp}, 32'd0);
            if (j == 100) check_eq("flash_on_100", {29'd0, ew_lamp}, {29'd0, R});
        end

        restart();
        step(3'b011, G, 1'b0, 1'b0);
        check_eq("illegal", {22'd0, ns_lamp, ew_lamp, fault, fault_code}, {22'd0, R, R, 1'b1, 3'd1});

        restart();
        repeat (30) step(G, R, 1'b0, 1'b0);
        repeat (5) step(Y, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        check_eq("short_yellow", {28'd0, fault, fault_code}, {28'd0, 1'b1, 3'd4});

        restart();
        repeat (30) step(G, R, 1'b0, 1'b0);
        repeat (20) step(Y, R, 1'b0, 1'b0);
        step(R, R, 1'b0, 1'b0);
        check_eq("yellow_20", {31'd0, fault}, 32'd0);

        repeat (10) step(R, R, 1'b0, 1'b0);
        step(G, R, 1'b0, 1'b0);
        n_green = 1;
        hit = 1'b0;
        for (int i = 0; i < 250 && !hit; i++) begin
            step(G, R, 1'b0, 1'b0);
            if (fault) hit = 1'b1;
            else n_green++;
        end
        check_eq("stuck_code", {29'd0, fault_code}, 32'd6);
        check_eq("stuck_cycles", n_green, MAX_PH);

        step(R, R, 1'b1, 1'b0);
        check_eq("clear", {28'd0, fault, fault_code}, 32'd0);
        fault_seen = 0;
        for (int k = 1; k <= 300; k++) begin
            c = ctrl_out(k - 1);
            step(c[5:3], c[2:0], 1'b0, 1'b0);
            if (fault) fault_seen++;
            if (k == 10) check_eq("clear_red", {26'd0, ns_lamp, ew_lamp}, {26'd0, R, R});
        end
        check_eq("post_clear_faults", fault_seen, 0);

        step(G, G, 1'b0, 1'b0);
        step(R, R, 1'b1, 1'b1);
        check_eq("rst_over_clear", {22'd0, ns_lamp, ew_lamp, fault, fault_code}, {22'd0, 10'b100_100_0_000});
        repeat (11) step(R, R, 1'b0, 1'b0);
        repeat (30) step(G, R, 1'b0, 1'b0);
        repeat (20) step(Y, R, 1'b0, 1'b0);
        step(R, G, 1'b0, 1'b0);
        check_eq("yellow_to_ew_green", {28'd0, fault, fault_code}, {28'd0, 1'b1, 3'd3});

        rn = R;
        re = R;
        for (int k = 0; k < 2000; k++) begin
            p = $urandom_range(0, 999);
            q = $urandom_range(0, 99);
            rclr = (p < 30);
            rrst = (p >= 30 && p < 33);
            if (q < 6)       rn = succ(rn);
            else if (q < 12) re = succ(re);
            else if (q < 14) rn = 3'($urandom_range(0, 7));
            else if (q < 16) re = 3'($urandom_range(0, 7));
            step(rn, re, rclr, rrst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
